// File: rtl/tv_adv7180_init.sv
// ADV7180 register initialiser: walks a fixed 7-entry (register, value) table
// and issues one bus write per entry to the I2C register block, waiting for the
// block to go busy and then idle, then idling for a settle period before the
// next entry. The first entry is a soft reset, so it gets an extra wait.
module tv_adv7180_init #(
    parameter int unsigned ADDRESS           = 0,
    parameter int          BUS_ADDR_DATA_LEN = 16,
    parameter int unsigned SETTLE_CYCLES     = 1000,
    parameter int unsigned RESET_WAIT        = 100000,
    parameter int unsigned ACK_TIMEOUT       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [BUS_ADDR_DATA_LEN-1:0] addr,
    output logic                         wr,
    output logic [7:0]                   bus_out,
    input  logic                         stall,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned SETTLE_MAX = RESET_WAIT + SETTLE_CYCLES;
    localparam int SETTLE_W = (SETTLE_MAX < 2) ? 1 : $clog2(SETTLE_MAX + 1);
    localparam int TO_W     = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_FIRST = SETTLE_W'(SETTLE_MAX);
    localparam logic [SETTLE_W-1:0] SETTLE_NORM  = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [TO_W-1:0]     TO_LAST      = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [2:0]          LAST_IDX     = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_FREE,
        S_SETTLE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                       r_state, w_nextState;
    logic [2:0]                   r_idx, w_nextIdx;
    logic [SETTLE_W-1:0]          r_settleCnt, w_nextSettleCnt;
    logic [TO_W-1:0]              r_toCnt, w_nextToCnt;
    logic [BUS_ADDR_DATA_LEN-1:0] r_addr, w_nextAddr;
    logic                         r_wr, w_nextWr;
    logic [7:0]                   r_busOut, w_nextBusOut;
    logic                         r_busy, w_nextBusy;
    logic                         r_done, w_nextDone;
    logic                         r_err, w_nextErr;
    logic [7:0]                   w_tblReg;
    logic [7:0]                   w_tblVal;
    logic [BUS_ADDR_DATA_LEN-1:0] w_issueAddr;

    assign addr    = r_addr;
    assign wr      = r_wr;
    assign bus_out = r_busOut;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

    assign w_issueAddr = BUS_ADDR_DATA_LEN'(ADDRESS) + BUS_ADDR_DATA_LEN'(w_tblReg);

    // Init table lookup: entry 0 is the soft reset, the rest configure input and output format.
    always_comb begin
        w_tblReg = 8'h00;
        w_tblVal = 8'h00;
        case (r_idx)
            3'd0: begin w_tblReg = 8'h0F; w_tblVal = 8'h80; end
            3'd1: begin w_tblReg = 8'h00; w_tblVal = 8'h00; end
            3'd2: begin w_tblReg = 8'h04; w_tblVal = 8'h57; end
            3'd3: begin w_tblReg = 8'h17; w_tblVal = 8'h41; end
            3'd4: begin w_tblReg = 8'h31; w_tblVal = 8'h02; end
            3'd5: begin w_tblReg = 8'h3D; w_tblVal = 8'hA2; end
            3'd6: begin w_tblReg = 8'h0E; w_tblVal = 8'h00; end
            default: begin w_tblReg = 8'h00; w_tblVal = 8'h00; end
        endcase
    end

    // Sequencer next-state logic; all bus outputs are registered so they never glitch.
    always_comb begin
        w_nextState     = r_state;
        w_nextIdx       = r_idx;
        w_nextSettleCnt = r_settleCnt;
        w_nextToCnt     = r_toCnt;
        w_nextAddr      = r_addr;
        w_nextWr        = r_wr;
        w_nextBusOut    = r_busOut;
        w_nextBusy      = r_busy;
        w_nextDone      = r_done;
        w_nextErr       = r_err;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_nextDone  = 1'b0;
                    w_nextErr   = 1'b0;
                    w_nextIdx   = 3'd0;
                    w_nextBusy  = 1'b1;
                    w_nextState = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_nextAddr   = w_issueAddr;
                w_nextBusOut = w_tblVal;
                w_nextWr     = 1'b1;
                w_nextToCnt  = '0;
                w_nextState  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (stall) begin
                    w_nextWr    = 1'b0;
                    w_nextState = S_WAIT_FREE;
                end else if (r_toCnt >= TO_LAST) begin
                    w_nextWr     = 1'b0;
                    w_nextAddr   = '0;
                    w_nextBusOut = 8'h00;
                    w_nextToCnt  = '0;
                    w_nextBusy   = 1'b0;
                    w_nextErr    = 1'b1;
                    w_nextState  = S_ERROR;
                end else begin
                    w_nextToCnt = r_toCnt + TO_W'(1);
                end
            end
            S_WAIT_FREE: begin
                if (!stall) begin
                    w_nextAddr      = '0;
                    w_nextBusOut    = 8'h00;
                    w_nextSettleCnt = (r_idx == 3'd0) ? SETTLE_FIRST : SETTLE_NORM;
                    w_nextState     = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_settleCnt <= SETTLE_W'(1)) begin
                    w_nextSettleCnt = '0;
                    if (r_idx == LAST_IDX) begin
                        w_nextBusy  = 1'b0;
                        w_nextDone  = 1'b1;
                        w_nextState = S_DONE;
                    end else begin
                        w_nextIdx   = r_idx + 3'd1;
                        w_nextState = S_ISSUE;
                    end
                end else begin
                    w_nextSettleCnt = r_settleCnt - SETTLE_W'(1);
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops everything to idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 3'd0;
            r_settleCnt <= '0;
            r_toCnt     <= '0;
            r_addr      <= '0;
            r_wr        <= 1'b0;
            r_busOut    <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_idx       <= w_nextIdx;
            r_settleCnt <= w_nextSettleCnt;
            r_toCnt     <= w_nextToCnt;
            r_addr      <= w_nextAddr;
            r_wr        <= w_nextWr;
            r_busOut    <= w_nextBusOut;
            r_busy      <= w_nextBusy;
            r_done      <= w_nextDone;
            r_err       <= w_nextErr;
        end
    end

endmodule

// File: tb/tb_tv_adv7180_init.sv
// Bench for tv_adv7180_init: a stall model stands in for the I2C register
// block, expected writes are queued when a run is started, and a monitor pops
// and compares them every time wr rises.
module tb_tv_adv7180_init;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  bus_out;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          gap;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   writes = 0;
    int   lastFallCyc = 0;
    bit   stallEnable = 1'b1;
    bit   pendingRise = 1'b0;
    int   holdCnt = 0;
    logic prevWr = 1'b0;

    logic [15:0] expAddr[7];
    logic [7:0]  expData[7];

    tv_adv7180_init #(
        .ADDRESS(32'h100),
        .BUS_ADDR_DATA_LEN(16),
        .SETTLE_CYCLES(10),
        .RESET_WAIT(50),
        .ACK_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .addr(addr),
        .wr(wr),
        .bus_out(bus_out),
        .stall(stall),
        .busy(busy),
        .done(done),
        .err(err)
    );

    // Free-running 100 MHz clock and an edge counter used for gap timing.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Register-block model: stall rises one cycle after wr is seen and stays high 40 cycles.
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            stall = 1'b0;
            holdCnt = 0;
            pendingRise = 1'b0;
        end else if (holdCnt > 0) begin
            holdCnt--;
            if (holdCnt == 0) begin
                stall = 1'b0;
                lastFallCyc = cyc;
            end
        end else if (pendingRise) begin
            stall = 1'b1;
            holdCnt = 40;
            pendingRise = 1'b0;
        end else if (stallEnable && wr) begin
            pendingRise = 1'b1;
        end
    end

    // Monitor: every rising wr must match the next queued write, and its gap if one is expected.
    always begin
        @(posedge clk);
        #1;
        if (!rst && wr && !prevWr) begin
            writes++;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWrite", {16'h0, addr}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput($sformatf("writeAddr%0d", writes), {16'h0, addr}, {16'h0, e.addr});
                checkOutput($sformatf("writeData%0d", writes), {24'h0, bus_out}, {24'h0, e.data});
                if (e.gap >= 0)
                    checkOutput($sformatf("writeGap%0d", writes), cyc - lastFallCyc, e.gap);
            end
        end
        prevWr = wr;
    end

    task automatic startPulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Queue the first n table writes (with expected settle gaps if requested) and start a run.
    task automatic applyStimulus(input int n, input bit withGaps);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.addr = expAddr[i];
            e.data = expData[i];
            if (!withGaps || i == 0) e.gap = -1;
            else if (i == 1)         e.gap = 62;
            else                     e.gap = 12;
            expQ.push_back(e);
        end
        startPulse();
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, {31'h0, done}, 32'h1);
    endtask

    task automatic waitErr(input string name);
        int n;
        n = 0;
        while (!err && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, {31'h0, err}, 32'h1);
    endtask

    initial begin
        int base;
        int len;
        int n;
        expAddr = '{16'h10F, 16'h100, 16'h104, 16'h117, 16'h131, 16'h13D, 16'h10E};
        expData = '{8'h80, 8'h00, 8'h57, 8'h41, 8'h02, 8'hA2, 8'h00};

        // Reset state, and no start of its own afterwards.
        repeat (3) @(negedge clk);
        checkOutput("resetAddr", {16'h0, addr}, 32'h0);
        checkOutput("resetWr", {31'h0, wr}, 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("idleBusy", {31'h0, busy}, 32'h0);
        checkOutput("idleWr", {31'h0, wr}, 32'h0);
        checkOutput("idleFlags", {30'h0, done, err}, 32'h0);
        checkOutput("idleWrites", writes, 0);

        // Full sequence with extra start pulses while busy.
        $display("[TB] full init sequence");
        base = writes;
        applyStimulus(7, 1'b1);
        checkOutput("busyAfterStart", {31'h0, busy}, 32'h1);
        for (int k = 0; k < 6; k++) begin
            repeat (41) @(negedge clk);
            startPulse();
        end
        waitDone("seqDone");
        checkOutput("seqBusy", {31'h0, busy}, 32'h0);
        checkOutput("seqErr", {31'h0, err}, 32'h0);
        checkOutput("seqAddrIdle", {16'h0, addr}, 32'h0);
        checkOutput("seqDataIdle", {24'h0, bus_out}, 32'h0);
        repeat (30) @(negedge clk);
        checkOutput("seqWriteCount", writes - base, 7);

        // Stall tied low: write times out, then a retry restarts from entry 0.
        $display("[TB] ack timeout");
        stallEnable = 1'b0;
        applyStimulus(1, 1'b0);
        checkOutput("doneClearedByStart", {31'h0, done}, 32'h0);
        n = 0;
        while (!wr && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        len = 0;
        while (wr && len < 100) begin
            len++;
            @(posedge clk);
            #1;
        end
        checkOutput("timeoutWrLen", len, 16);
        checkOutput("timeoutErr", {31'h0, err}, 32'h1);
        checkOutput("timeoutBusy", {31'h0, busy}, 32'h0);
        checkOutput("timeoutAddr", {16'h0, addr}, 32'h0);
        applyStimulus(1, 1'b0);
        checkOutput("retryErrCleared", {31'h0, err}, 32'h0);
        checkOutput("retryBusy", {31'h0, busy}, 32'h1);
        waitErr("retryErrAgain");

        // Reset while entry 3 waits for the register block to go idle.
        $display("[TB] reset mid-write");
        stallEnable = 1'b1;
        base = writes;
        applyStimulus(4, 1'b1);
        n = 0;
        while (!((writes - base) == 4 && stall && !wr) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("reachedWaitFree", writes - base, 4);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("waitFreeAddrHeld", {16'h0, addr}, 32'h117);
        checkOutput("waitFreeWrLow", {31'h0, wr}, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("asyncRstAddr", {16'h0, addr}, 32'h0);
        checkOutput("asyncRstData", {24'h0, bus_out}, 32'h0);
        checkOutput("asyncRstFlags", {28'h0, wr, busy, done, err}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("postRstBusy", {31'h0, busy}, 32'h0);
        base = writes;
        applyStimulus(7, 1'b1);
        waitDone("restartDone");
        checkOutput("restartWriteCount", writes - base, 7);
        checkOutput("scoreboardDrained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog in case the bench itself stops making progress.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
